// File: rtl/spi_pkg.sv
// Shared constants for the SPI command front-end: sequencer state encoding,
// transfer direction values and default widths/depths.
package spi_pkg;

    localparam int DEF_DATA_WIDTH    = 32;
    localparam int DEF_ADDRESS_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH    = 4;
    localparam int DEF_BUSY_TIMEOUT  = 8;
    localparam int BUSY_CNT_WIDTH    = 5;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 2'd0;
    localparam seq_state_t ST_ISSUE     = 2'd1;
    localparam seq_state_t ST_WAIT_BUSY = 2'd2;
    localparam seq_state_t ST_WAIT_DONE = 2'd3;

    // Same encoding as spi_master rd_we.
    localparam logic SPI_WR = 1'b1;
    localparam logic SPI_RD = 1'b0;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous first-word fall-through FIFO. Pointers carry one extra wrap bit
// so full and empty are told apart by comparing the MSBs.
module spi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign pop_data = mem[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is refused even when a pop happens the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Host-side command front-end for spi_master: queues write/read commands,
// issues them one at a time with a one-cycle enable pulse and queues read data.
module spi_cmd_sequencer
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int CMD_DEPTH     = DEF_FIFO_DEPTH,
    parameter int RSP_DEPTH     = DEF_FIFO_DEPTH,
    parameter int BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rd_we,
    input  logic [ADDRESS_WIDTH-1:0] cmd_address,
    input  logic [DATA_WIDTH-1:0]    cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic                     m_enable,
    output logic                     m_rd_we,
    output logic [ADDRESS_WIDTH-1:0] m_address,
    output logic [DATA_WIDTH-1:0]    m_data,
    input  logic                     m_busy,
    input  logic [DATA_WIDTH-1:0]    m_data_read,
    input  logic                     m_data_read_valid,
    output logic                     err_timeout,
    output logic                     err_no_data,
    input  logic                     err_clear,
    output logic                     idle
);

    localparam int CMD_WIDTH = 1 + ADDRESS_WIDTH + DATA_WIDTH;
    localparam int CMD_CW    = $clog2(CMD_DEPTH) + 1;
    localparam int RSP_CW    = $clog2(RSP_DEPTH) + 1;
    localparam logic [BUSY_CNT_WIDTH-1:0] TIMEOUT_CNT = BUSY_CNT_WIDTH'(BUSY_TIMEOUT);
    localparam logic [BUSY_CNT_WIDTH-1:0] CNT_ONE     = BUSY_CNT_WIDTH'(1);

    seq_state_t state_q;
    seq_state_t state_d;

    logic [CMD_WIDTH-1:0]      cmd_head;
    logic                      cmd_push;
    logic                      cmd_pop;
    logic                      cmd_full;
    logic                      cmd_empty;
    logic [CMD_CW-1:0]         cmd_count;
    logic                      head_rd_we;
    logic [ADDRESS_WIDTH-1:0]  head_address;
    logic [DATA_WIDTH-1:0]     head_data;

    logic                      rsp_push;
    logic                      rsp_pop;
    logic                      rsp_full;
    logic                      rsp_empty;
    logic [RSP_CW-1:0]         rsp_count;
    logic                      unused_rsp_count;

    logic                      load_cmd;
    logic                      set_timeout;
    logic                      set_no_data;
    logic [BUSY_CNT_WIDTH-1:0] busy_cnt_q;
    logic                      got_data_q;
    logic                      m_rd_we_q;
    logic [ADDRESS_WIDTH-1:0]  m_address_q;
    logic [DATA_WIDTH-1:0]     m_data_q;
    logic                      err_timeout_q;
    logic                      err_no_data_q;

    // Both host ports are valid/ready: a word moves on a rising edge where
    // valid && ready; valid must hold with stable payload until accepted, and
    // ready (FIFO not full / not empty) never depends on the same-cycle valid.
    assign cmd_push  = cmd_valid && !cmd_full;
    assign cmd_ready = !cmd_full;
    assign rsp_pop   = rsp_ready && !rsp_empty;
    assign rsp_valid = !rsp_empty;

    assign head_rd_we   = cmd_head[CMD_WIDTH-1];
    assign head_address = cmd_head[CMD_WIDTH-2 -: ADDRESS_WIDTH];
    assign head_data    = cmd_head[DATA_WIDTH-1:0];

    assign unused_rsp_count = ^rsp_count;

    spi_sync_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (cmd_push),
        .push_data ({cmd_rd_we, cmd_address, cmd_data}),
        .pop       (cmd_pop),
        .pop_data  (cmd_head),
        .full      (cmd_full),
        .empty     (cmd_empty),
        .count     (cmd_count)
    );

    spi_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (rsp_push),
        .push_data (m_data_read),
        .pop       (rsp_pop),
        .pop_data  (rsp_data),
        .full      (rsp_full),
        .empty     (rsp_empty),
        .count     (rsp_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A read only leaves IDLE once its response slot is free, so the capture
    // in WAIT_DONE can never be refused by the response FIFO.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty && (head_rd_we == SPI_WR || !rsp_full)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (m_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (busy_cnt_q == TIMEOUT_CNT) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!m_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        load_cmd    = 1'b0;
        m_enable    = 1'b0;
        cmd_pop     = 1'b0;
        rsp_push    = 1'b0;
        set_timeout = 1'b0;
        set_no_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_cmd = (state_d == ST_ISSUE);
            end
            ST_ISSUE: begin
                m_enable = 1'b1;
                cmd_pop  = 1'b1;
            end
            ST_WAIT_BUSY: begin
                set_timeout = !m_busy && (busy_cnt_q == TIMEOUT_CNT);
            end
            ST_WAIT_DONE: begin
                // Capture and the busy fall may coincide: capture wins, no error.
                if (m_rd_we_q == SPI_RD) begin
                    rsp_push    = m_data_read_valid && !got_data_q;
                    set_no_data = !m_busy && !got_data_q && !m_data_read_valid;
                end
            end
            default: begin
                load_cmd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            m_rd_we_q     <= 1'b0;
            m_address_q   <= '0;
            m_data_q      <= '0;
            busy_cnt_q    <= '0;
            got_data_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            err_no_data_q <= 1'b0;
        end else begin
            if (load_cmd) begin
                m_rd_we_q   <= head_rd_we;
                m_address_q <= head_address;
                m_data_q    <= head_data;
            end
            if (state_q == ST_ISSUE) begin
                busy_cnt_q <= '0;
                got_data_q <= 1'b0;
            end else begin
                if (state_q == ST_WAIT_BUSY && !m_busy) begin
                    busy_cnt_q <= busy_cnt_q + CNT_ONE;
                end
                if (rsp_push) begin
                    got_data_q <= 1'b1;
                end
            end
            if (err_clear) begin
                err_timeout_q <= 1'b0;
                err_no_data_q <= 1'b0;
            end else begin
                if (set_timeout) begin
                    err_timeout_q <= 1'b1;
                end
                if (set_no_data) begin
                    err_no_data_q <= 1'b1;
                end
            end
        end
    end

    assign m_rd_we     = m_rd_we_q;
    assign m_address   = m_address_q;
    assign m_data      = m_data_q;
    assign err_timeout = err_timeout_q;
    assign err_no_data = err_no_data_q;
    assign idle        = (state_q == ST_IDLE) && (cmd_count == '0);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed and randomized bench for spi_cmd_sequencer with a behavioural
// spi_master responder and a memory-based reference model of expected traffic.
module tb_spi_cmd_sequencer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 1 + AW + DW;
    localparam int MODE_NORMAL   = 0;
    localparam int MODE_NO_BUSY  = 1;
    localparam int MODE_NO_VALID = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rd_we;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          m_enable;
    logic          m_rd_we;
    logic [AW-1:0] m_address;
    logic [DW-1:0] m_data;
    logic          m_busy;
    logic [DW-1:0] m_data_read;
    logic          m_data_read_valid;
    logic          err_timeout;
    logic          err_no_data;
    logic          err_clear;
    logic          idle;

    always #5 clock = ~clock;

    spi_cmd_sequencer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .CMD_DEPTH     (4),
        .RSP_DEPTH     (4),
        .BUSY_TIMEOUT  (8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_rd_we         (cmd_rd_we),
        .cmd_address       (cmd_address),
        .cmd_data          (cmd_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_data          (rsp_data),
        .m_enable          (m_enable),
        .m_rd_we           (m_rd_we),
        .m_address         (m_address),
        .m_data            (m_data),
        .m_busy            (m_busy),
        .m_data_read       (m_data_read),
        .m_data_read_valid (m_data_read_valid),
        .err_timeout       (err_timeout),
        .err_no_data       (err_no_data),
        .err_clear         (err_clear),
        .idle              (idle)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [CW-1:0] exp_issue_q[$];
    logic [DW-1:0] exp_rsp_q[$];
    logic [DW-1:0] ref_mem    [logic [AW-1:0]];
    logic [DW-1:0] periph_mem [logic [AW-1:0]];
    int slave_mode  = MODE_NORMAL;
    int busy_len    = 4;
    bit rand_len    = 1'b0;
    int n_issued    = 0;
    int rst_epoch   = 0;
    int cyc         = 0;
    int last_en_cyc = 0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : ~a;
    endfunction

    // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
    task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int stalls);
        logic acc;
        acc         = 1'b0;
        stalls      = 0;
        cmd_valid   = 1'b1;
        cmd_rd_we   = we;
        cmd_address = a;
        cmd_data    = d;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            acc = cmd_ready;
            @(posedge clock);
            if (acc) break;
            stalls++;
        end
        #1 cmd_valid = 1'b0;
        check("cmd_accepted", acc, 1);
        if (acc) begin
            exp_issue_q.push_back({we, a, d});
            if (we) ref_mem[a] = d;
            else if (slave_mode == MODE_NORMAL) exp_rsp_q.push_back(ref_read(a));
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (idle) break;
        end
        check(tag, idle, 1);
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string tag);
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #1;
            if (exp_rsp_q.size() == 0) break;
        end
        rsp_ready = 1'b0;
        @(negedge clock);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_exp_left"}, exp_rsp_q.size(), 0);
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(posedge clock);
        #1 err_clear = 1'b0;
    endtask

    // spi_master stand-in: busy rises one cycle after enable, read data is
    // either a separate pulse before the busy fall or coincident with it.
    initial begin : slave
        logic          we_s;
        logic [AW-1:0] a_s;
        logic [DW-1:0] d_s;
        logic [DW-1:0] rdata;
        logic [CW-1:0] e;
        int            len;
        int            ep;
        bit            same;
        m_busy            = 1'b0;
        m_data_read_valid = 1'b0;
        m_data_read       = '0;
        forever begin
            @(negedge clock);
            if (reset_n && m_enable) begin
                ep   = rst_epoch;
                we_s = m_rd_we;
                a_s  = m_address;
                d_s  = m_data;
                n_issued++;
                check("issue_expected", exp_issue_q.size() != 0, 1);
                if (exp_issue_q.size() != 0) begin
                    e = exp_issue_q.pop_front();
                    check("issue_cmd", {we_s, a_s, d_s}, e);
                end
                if (slave_mode != MODE_NO_BUSY) begin
                    if (we_s) periph_mem[a_s] = d_s;
                    rdata = periph_mem.exists(a_s) ? periph_mem[a_s] : ~a_s;
                    len   = rand_len ? $urandom_range(2, 6) : busy_len;
                    same  = 1'($urandom_range(0, 1));
                    @(negedge clock);
                    m_busy = 1'b1;
                    repeat (len - 1) @(negedge clock);
                    if (!we_s && slave_mode == MODE_NORMAL && !same) begin
                        m_data_read_valid = 1'b1;
                        m_data_read       = rdata;
                        @(negedge clock);
                        m_data_read_valid = 1'b0;
                    end
                    if (!we_s && slave_mode == MODE_NORMAL && same) begin
                        m_data_read_valid = 1'b1;
                        m_data_read       = rdata;
                    end
                    if (ep == rst_epoch) check("m_data_stable", {m_rd_we, m_address, m_data}, {we_s, a_s, d_s});
                    m_busy = 1'b0;
                    @(negedge clock);
                    m_data_read_valid = 1'b0;
                end
            end
        end
    end

    initial begin : enable_monitor
        forever begin
            @(negedge clock);
            cyc++;
            if (reset_n && m_enable) begin
                if (last_en_cyc > 0) check("enable_gap", (cyc - last_en_cyc) >= 3, 1);
                last_en_cyc = cyc;
            end
        end
    end

    initial begin : rsp_monitor
        forever begin
            @(negedge clock);
            if (reset_n && rsp_valid && rsp_ready) begin
                check("rsp_expected", exp_rsp_q.size() != 0, 1);
                if (exp_rsp_q.size() != 0) check("rsp_data", rsp_data, exp_rsp_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int            st;
        int            base;
        int            k;
        logic          we;
        logic [AW-1:0] a;

        reset_n     = 1'b0;
        cmd_valid   = 1'b0;
        cmd_rd_we   = 1'b0;
        cmd_address = '0;
        cmd_data    = '0;
        rsp_ready   = 1'b0;
        err_clear   = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_idle", idle, 1);
        check("rst_m_enable", m_enable, 0);
        check("rst_m_rd_we", m_rd_we, 0);
        check("rst_m_address", m_address, 0);
        check("rst_m_data", m_data, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_no_data", err_no_data, 0);
        @(posedge clock);
        #1;

        // Single write and its issue latency.
        push_cmd(1'b1, 32'h10, 32'hA5A5A5A5, st);
        @(negedge clock);
        check("lat_enable_n1", m_enable, 0);
        @(negedge clock);
        check("lat_enable_n2", m_enable, 1);
        check("wr_rd_we", m_rd_we, 1);
        check("wr_address", m_address, 32'h10);
        check("wr_data", m_data, 32'hA5A5A5A5);
        @(posedge clock);
        #1;
        wait_idle("wr_idle", 60);
        check("wr_no_rsp", rsp_valid, 0);

        // Single read of a preloaded peripheral location.
        ref_mem[32'h10]    = 32'h3C3C3C3C;
        periph_mem[32'h10] = 32'h3C3C3C3C;
        push_cmd(1'b0, 32'h10, 32'h0, st);
        wait_idle("rd_idle", 60);
        @(negedge clock);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_data", rsp_data, 32'h3C3C3C3C);
        check("rd_err_timeout", err_timeout, 0);
        check("rd_err_no_data", err_no_data, 0);
        @(posedge clock);
        #1;
        drain("rd");

        // Command FIFO fills while a long write is in flight.
        rand_len = 1'b0;
        busy_len = 40;
        push_cmd(1'b1, 32'h100, $urandom, st);
        wait_cycles(6);
        for (int i = 0; i < 4; i++) begin
            push_cmd(1'b1, 32'h104 + 32'(i * 4), $urandom, st);
            check("burst_no_stall", st, 0);
        end
        @(negedge clock);
        check("burst_full_ready", cmd_ready, 0);
        @(posedge clock);
        #1;
        push_cmd(1'b1, 32'h114, $urandom, st);
        check("burst_fifth_held", st > 0, 1);
        wait_idle("burst_idle", 500);

        // Response FIFO full holds back the fifth read.
        busy_len = 4;
        base     = n_issued;
        for (int i = 0; i < 5; i++) push_cmd(1'b0, 32'h104 + 32'(i * 4), $urandom, st);
        wait_cycles(120);
        @(negedge clock);
        check("rspfull_issued4", n_issued - base, 4);
        check("rspfull_valid", rsp_valid, 1);
        check("rspfull_not_idle", idle, 0);
        @(posedge clock);
        #1 rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        wait_cycles(40);
        check("rspfull_issued5", n_issued - base, 5);
        drain("rspfull");

        // Randomized mix with random busy lengths and valid/busy-fall overlap.
        rand_len  = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 7) * 4);
            push_cmd(we, a, $urandom, st);
            wait_cycles($urandom_range(0, 3));
        end
        wait_idle("rand_idle", 600);
        drain("rand");
        check("rand_issue_left", exp_issue_q.size(), 0);
        check("rand_err_timeout", err_timeout, 0);
        check("rand_err_no_data", err_no_data, 0);

        // Busy never rises: timeout, no response, then recovery.
        rand_len   = 1'b0;
        slave_mode = MODE_NO_BUSY;
        push_cmd(1'b0, 32'h20, 32'h0, st);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (m_enable) break;
        end
        k = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            k++;
            if (err_timeout) break;
        end
        check("to_window", (k >= 8) && (k <= 11), 1);
        check("to_flag", err_timeout, 1);
        check("to_no_rsp", rsp_valid, 0);
        check("to_no_data_flag", err_no_data, 0);
        @(posedge clock);
        #1;
        wait_idle("to_idle", 20);
        pulse_clear();
        @(negedge clock);
        check("to_cleared", err_timeout, 0);
        @(posedge clock);
        #1;
        slave_mode = MODE_NORMAL;
        base       = n_issued;
        push_cmd(1'b1, 32'h24, 32'hDEADBEEF, st);
        wait_idle("to_recover_idle", 60);
        check("to_recover_issued", n_issued - base, 1);

        // Read completes without data: sticky no-data error.
        slave_mode = MODE_NO_VALID;
        push_cmd(1'b0, 32'h24, 32'h0, st);
        wait_idle("nd_idle", 60);
        @(negedge clock);
        check("nd_flag", err_no_data, 1);
        check("nd_no_rsp", rsp_valid, 0);
        check("nd_to_flag", err_timeout, 0);
        @(posedge clock);
        #1;
        pulse_clear();
        @(negedge clock);
        check("nd_cleared", err_no_data, 0);
        @(posedge clock);
        #1;

        // Reset while a read is in WAIT_DONE.
        slave_mode = MODE_NORMAL;
        busy_len   = 12;
        push_cmd(1'b0, 32'h28, 32'h0, st);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (m_busy) break;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("mid_not_idle", idle, 0);
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_m_enable", m_enable, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_err_timeout", err_timeout, 0);
        check("mid_rst_err_no_data", err_no_data, 0);
        check("mid_rst_m_address", m_address, 0);
        rst_epoch++;
        exp_rsp_q.delete();
        exp_issue_q.delete();
        @(posedge clock);
        #1 reset_n = 1'b1;
        wait_cycles(20);
        check("mid_rst_no_rsp", rsp_valid, 0);

        // Normal traffic after the mid-transaction reset.
        busy_len = 4;
        push_cmd(1'b1, 32'h30, 32'h5A5A0F0F, st);
        push_cmd(1'b0, 32'h30, 32'h0, st);
        wait_idle("post_idle", 100);
        drain("post");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Command front-end sitting directly upstream of spi_master: buffers write/read requests from a host-side valid/ready port and issues them one at a time on spi_master's enable/rd_we/address/data interface.
- Collects read data returned on data_read/data_read_valid into a response FIFO drained by the host.
- Owns enable-pulse generation, busy tracking, timeout and error reporting, so host logic never touches spi_master timing.

Parameters:
DATA_WIDTH, 32, width of write data and read data
ADDRESS_WIDTH, 32, width of SPI address
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
RSP_DEPTH, 4, response FIFO entries (power of two, >=2)
BUSY_TIMEOUT, 8, max cycles from enable pulse to busy rising

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  synchronous, active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command FIFO not full
cmd_rd_we  in  1  1 = write, 0 = read (same encoding as spi_master rd_we)
cmd_address  in  ADDRESS_WIDTH  target address
cmd_data  in  DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  host pops response
rsp_data  out  DATA_WIDTH  head of response FIFO (first-word fall-through)
m_enable  out  1  one-cycle start pulse to spi_master enable
m_rd_we  out  1  to spi_master rd_we
m_address  out  ADDRESS_WIDTH  to spi_master address
m_data  out  DATA_WIDTH  to spi_master data
m_busy  in  1  spi_master busy
m_data_read  in  DATA_WIDTH  spi_master data_read
m_data_read_valid  in  1  spi_master data_read_valid
err_timeout  out  1  sticky: busy never rose after enable
err_no_data  out  1  sticky: read finished without data_read_valid
err_clear  in  1  clears both sticky flags
idle  out  1  FSM in IDLE and command FIFO empty

Behaviour:
- Reset (reset_n low at clock edge): both FIFOs empty, FSM IDLE; m_enable, m_rd_we, err_* = 0; m_address, m_data = 0; cmd_ready = 1, rsp_valid = 0, idle = 1. Reset mid-transaction abandons the command with no response; spi_master is reset by the same reset_n.
- Command push on cmd_valid && cmd_ready. cmd_ready = !full; when full, push refused even if a pop occurs the same cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE -> ISSUE when command FIFO non-empty AND (head is write OR response FIFO has a free slot). A read is never issued without a reserved response slot.
- ISSUE (1 cycle): m_enable = 1; m_rd_we/m_address/m_data loaded from head. They stay stable until the next ISSUE. Head popped this cycle. -> WAIT_BUSY.
- Latency: command pushed at edge N into an empty FIFO with FSM IDLE -> m_enable high in cycle N+2.
- WAIT_BUSY: 5-bit counter from 0. On m_busy = 1 -> WAIT_DONE. If the counter reaches BUSY_TIMEOUT with busy low: set err_timeout, no response pushed -> IDLE.
- WAIT_DONE:
  - Read: capture m_data_read on the m_data_read_valid pulse and push to the response FIFO (slot guaranteed).
  - Exit when m_busy = 0 -> IDLE.
  - If valid and the busy fall occur in the same cycle, capture first, then exit.
  - Read exits without a captured valid -> set err_no_data, no push.
  - m_data_read_valid during a write or in any other state is ignored.
- Only one transaction outstanding. IDLE lasts at least one cycle between transactions, so m_enable pulses are separated by at least 2 low cycles.
- Response FIFO: pop on rsp_valid && rsp_ready. A push and a pop in the same cycle are both honoured when not empty.
- err_clear takes priority over a same-cycle set (clear wins).
- FIFO pointers are log2(depth)+1 bits; full/empty come from MSB comparison; pointers wrap naturally.

Decomposition:
- Shared package spi_pkg: FSM state encoding (2-bit localparams), SPI_WR = 1'b1 / SPI_RD = 1'b0 constants, default width constants.
- One sub-module, spi_sync_fifo (parameterised WIDTH/DEPTH, first-word fall-through, full/empty/count), instantiated twice:
  - command FIFO: WIDTH = 1 + ADDRESS_WIDTH + DATA_WIDTH
  - response FIFO: WIDTH = DATA_WIDTH

Test Plan:
- Single write 0x00000010/0xA5A5A5A5 with spi_master model (divider 2) -> one m_enable pulse at N+2, m_rd_we = 1, m_data stable until busy falls, no response, idle returns to 1.
- Single read 0x10, model returns 0x3C3C3C3C -> rsp_valid rises after busy falls with rsp_data = 0x3C3C3C3C, err_* = 0.
- Push 5 writes back-to-back with busy held high long -> cmd_ready drops after 4 accepted, 5th held off; all 5 issued in order, pulses at least 2 cycles apart.
- rsp_ready = 0, issue 5 reads -> 4 responses queued; 5th read not issued (m_enable stays low) until one pop, then it issues and returns correct data.
- m_busy tied 0, issue a read -> err_timeout = 1 eight cycles after enable, no response; err_clear -> 0; next command still issues.
- Assert reset_n low during WAIT_DONE of a read -> next edge: FIFOs empty, m_enable = 0, rsp_valid = 0, err_* = 0, idle = 1.
